// File: rtl/aes_pkg.sv
// Shared types and helpers for the ShiftRows / InvShiftRows pipeline.
// The state is handled as 4 rows by up to NB_MAX columns of bytes, with
// byte s[r][c] living at bit offset 8*(4*c+r) of the flat data bus.
package aes_pkg;

  localparam int NB_MAX    = 8;
  localparam int DW_MAX    = 32 * NB_MAX;
  localparam int TAG_W_MAX = 16;

  typedef logic [3:0][NB_MAX-1:0][7:0] state_t;

  typedef struct packed {
    logic                 inv;
    logic [TAG_W_MAX-1:0] tag;
    logic [DW_MAX-1:0]    data;
  } beat_t;

  // Rijndael row offsets: 256-bit blocks skip offset 2 on the lower rows.
  function automatic int shift_off(input int nb, input int row);
    return (nb == 8 && row >= 2) ? row + 1 : row;
  endfunction

  // Cyclic left (forward) or right (inverse) rotation of each row by its offset.
  // Columns at or beyond nb are left zero.
  function automatic logic [DW_MAX-1:0] shift_rows(input logic [DW_MAX-1:0] d,
                                                   input int nb,
                                                   input logic inv);
    state_t            s;
    state_t            o;
    logic [DW_MAX-1:0] res;
    int                src;
    logic [2:0]        src3;
    s   = '0;
    o   = '0;
    res = '0;
    for (int c = 0; c < NB_MAX; c++) begin
      for (int r = 0; r < 4; r++) begin
        s[r][c] = d[8*(4*c+r) +: 8];
      end
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < NB_MAX; c++) begin
        if (c < nb) begin
          src = inv ? (c + nb - shift_off(nb, r)) : (c + shift_off(nb, r));
          if (src >= nb) src = src - nb;
          src3 = 3'(src);
          o[r][c] = s[r][src3];
        end
      end
    end
    for (int c = 0; c < NB_MAX; c++) begin
      for (int r = 0; r < 4; r++) begin
        res[8*(4*c+r) +: 8] = o[r][c];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/aes_pipe_reg.sv
// One valid/ready register slice. Loads whenever it is empty or its
// downstream drains in the same cycle, so a chain runs at full rate.
// A flush empties the slice and swallows any beat offered that cycle.
module aes_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q;
  logic [W-1:0] data_q;

  assign in_ready  = flush | ~valid_q | out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Valid follows the handshake; data only moves on an accepted, unflushed beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (in_ready) begin
        valid_q <= in_valid;
      end
      if (!flush && in_ready && in_valid) begin
        data_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/aes_shiftrow_pipe.sv
// Pipelined Rijndael ShiftRows / InvShiftRows with valid/ready handshake.
// The row permutation is combinational ahead of the first register; the
// tag rides alongside the data through PIPE_STAGES slices.
// Optional feature: define AES_SHIFTROW_BYPASS_EN to add byp_i, which
// passes a beat through unpermuted with the same latency.
module aes_shiftrow_pipe
  import aes_pkg::*;
#(
  parameter int NB          = 4,
  parameter int PIPE_STAGES = 1,
  parameter int TAG_W       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              inv_i,
`ifdef AES_SHIFTROW_BYPASS_EN
  input  logic              byp_i,
`endif
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [32*NB-1:0]  din,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [TAG_W-1:0]  tag_o,
  output logic [32*NB-1:0]  do1,
  output logic              busy_o
);

  localparam int DW = 32 * NB;
  localparam int PW = TAG_W + DW;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("aes_shiftrow_pipe: NB must be 4, 6 or 8");
  end
  if (PIPE_STAGES < 1 || PIPE_STAGES > 3) begin : g_bad_stages
    $error("aes_shiftrow_pipe: PIPE_STAGES must be 1..3");
  end
  if (TAG_W < 1 || TAG_W > TAG_W_MAX) begin : g_bad_tag
    $error("aes_shiftrow_pipe: TAG_W out of range");
  end

  logic [DW-1:0]          perm;
  logic [PIPE_STAGES:0]   vld;
  logic [PIPE_STAGES:0]   rdy;
  logic [PW-1:0]          pdat [PIPE_STAGES+1];

  // Permute the incoming state in the direction carried by this beat.
  always_comb begin
    perm = DW'(shift_rows(DW_MAX'(din), NB, inv_i));
`ifdef AES_SHIFTROW_BYPASS_EN
    if (byp_i) perm = din;
`endif
  end

  assign vld[0]           = in_valid_i;
  assign pdat[0]          = {tag_i, perm};
  assign rdy[PIPE_STAGES] = out_ready_i;

  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
    aes_pipe_reg #(.W(PW)) u_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush_i),
      .in_valid  (vld[k]),
      .in_ready  (rdy[k]),
      .in_data   (pdat[k]),
      .out_valid (vld[k+1]),
      .out_ready (rdy[k+1]),
      .out_data  (pdat[k+1])
    );
  end

  assign in_ready_o     = rdy[0];
  assign out_valid_o    = vld[PIPE_STAGES];
  assign {tag_o, do1}   = pdat[PIPE_STAGES];
  assign busy_o         = |vld[PIPE_STAGES:1];

endmodule
